// File: rtl/alu_pipe_if.sv
// Operand/result handshake bundle for alu_pipe.
// The producer drives the master side and the ALU sits on the slave side.
interface alu_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             carry;
  logic             zero;
  logic             overflow;
  logic             div_zero;
  logic             illegal;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, result_hi,
    input  carry, zero, overflow, div_zero, illegal
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, result_hi,
    output carry, zero, overflow, div_zero, illegal
  );
endinterface

// File: rtl/alu_pipe.sv
// Handshaked ALU: single-cycle add/sub/mul/logic ops plus an iterative
// restoring divider (WIDTH steps) returning quotient and remainder.
module alu_pipe #(
  parameter int          WIDTH       = 8,
  parameter int unsigned ILLEGAL_VAL = 'hAC
) (
  input  logic       clock,
  input  logic       reset,
  alu_pipe_if.slave  bus,
  output logic [1:0] dbg_state
);
  localparam int               CW      = $clog2(WIDTH);
  localparam int               MSB     = WIDTH - 1;
  localparam logic [WIDTH-1:0] ILL_RES = WIDTH'(ILLEGAL_VAL);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_DIV = 2'd1, ST_HOLD = 2'd2} state_t;

  state_t state, state_n;

  logic [WIDTH-1:0] res_q, hi_q;
  logic             carry_q, zero_q, ovf_q, dz_q, ill_q;
  logic [WIDTH-1:0] quo_q, rem_q, dsr_q;
  logic [CW-1:0]    cnt_q;

  // Handshake: a transfer happens on a cycle where valid and ready are both
  // high at the rising edge; valid never waits on ready, ready may follow valid.
  logic accept, div_start;
  assign bus.in_ready  = (state == ST_IDLE) || ((state == ST_HOLD) && bus.out_ready);
  assign bus.out_valid = (state == ST_HOLD);
  assign accept        = bus.in_valid && bus.in_ready;
  assign div_start     = accept && (bus.op == OP_DIV) && (bus.b != '0);

  logic [WIDTH:0]     sum, dif;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   c_res, c_hi;
  logic               c_carry, c_ovf, c_dz, c_ill;

  always_comb begin
    sum     = {1'b0, bus.a} + {1'b0, bus.b};
    dif     = {1'b0, bus.a} - {1'b0, bus.b};
    prod    = {{WIDTH{1'b0}}, bus.a} * {{WIDTH{1'b0}}, bus.b};
    c_res   = '0;
    c_hi    = '0;
    c_carry = 1'b0;
    c_ovf   = 1'b0;
    c_dz    = 1'b0;
    c_ill   = 1'b0;
    case (bus.op)
      OP_ADD: begin
        c_res   = sum[WIDTH-1:0];
        c_carry = sum[WIDTH];
        c_ovf   = (bus.a[MSB] == bus.b[MSB]) && (sum[MSB] != bus.a[MSB]);
      end
      OP_SUB: begin
        c_res   = dif[WIDTH-1:0];
        c_carry = dif[WIDTH];
        c_ovf   = (bus.a[MSB] != bus.b[MSB]) && (dif[MSB] != bus.a[MSB]);
      end
      OP_MUL: begin
        c_res = prod[WIDTH-1:0];
        c_hi  = prod[2*WIDTH-1:WIDTH];
        c_ovf = |prod[2*WIDTH-1:WIDTH];
      end
      // Only the b == 0 case is resolved here; b != 0 goes through the divider.
      OP_DIV: begin
        c_res = '1;
        c_hi  = bus.a;
        c_dz  = 1'b1;
      end
      OP_AND: c_res = bus.a & bus.b;
      OP_OR:  c_res = bus.a | bus.b;
      OP_XOR: c_res = bus.a ^ bus.b;
      default: begin
        c_res = ILL_RES;
        c_ill = 1'b1;
      end
    endcase
  end

  // One restoring step: shift in the next dividend bit, keep the trial
  // subtraction only when it does not go negative.
  logic [WIDTH:0]   rem_sh, trial;
  logic             q_bit;
  logic [WIDTH-1:0] rem_nx, quo_nx;

  always_comb begin
    rem_sh = {rem_q, quo_q[MSB]};
    trial  = rem_sh - {1'b0, dsr_q};
    q_bit  = ~trial[WIDTH];
    rem_nx = q_bit ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quo_nx = {quo_q[WIDTH-2:0], q_bit};
  end

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (accept) state_n = div_start ? ST_DIV : ST_HOLD;
      ST_DIV:  if (cnt_q == '0) state_n = ST_HOLD;
      ST_HOLD: begin
        if (accept)             state_n = div_start ? ST_DIV : ST_HOLD;
        else if (bus.out_ready) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      res_q   <= '0;
      hi_q    <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
      ill_q   <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dsr_q   <= '0;
      cnt_q   <= '0;
    end else if (accept) begin
      if (div_start) begin
        quo_q <= bus.a;
        rem_q <= '0;
        dsr_q <= bus.b;
        cnt_q <= CW'(WIDTH - 1);
      end else begin
        res_q   <= c_res;
        hi_q    <= c_hi;
        carry_q <= c_carry;
        zero_q  <= (c_res == '0);
        ovf_q   <= c_ovf;
        dz_q    <= c_dz;
        ill_q   <= c_ill;
      end
    end else if (state == ST_DIV) begin
      quo_q <= quo_nx;
      rem_q <= rem_nx;
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == '0) begin
        res_q   <= quo_nx;
        hi_q    <= rem_nx;
        carry_q <= 1'b0;
        zero_q  <= (quo_nx == '0);
        ovf_q   <= 1'b0;
        dz_q    <= 1'b0;
        ill_q   <= 1'b0;
      end
    end
  end

  assign bus.result    = res_q;
  assign bus.result_hi = hi_q;
  assign bus.carry     = carry_q;
  assign bus.zero      = zero_q;
  assign bus.overflow  = ovf_q;
  assign bus.div_zero  = dz_q;
  assign bus.illegal   = ill_q;
  assign dbg_state     = state;
endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed vector table, hand-written handshake/reset
// sequences, then random traffic scored against an arithmetic model.
module tb_alu_pipe;
  localparam int W  = 8;
  localparam int EW = 2 * W + 5;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] dbg_state;

  always #5 clock = ~clock;

  alu_pipe_if #(.WIDTH(W)) bus ();

  alu_pipe #(.WIDTH(W), .ILLEGAL_VAL('hAC)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  int tests = 0;
  int fails = 0;
  logic [EW-1:0] exp_q[$];

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a, b, res, hi;
    logic         c, z, o, dz, il;
    int           lat;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] actual();
    return {bus.result, bus.result_hi, bus.carry, bus.zero, bus.overflow,
            bus.div_zero, bus.illegal};
  endfunction

  // Reference: plain integer arithmetic on the operand values.
  function automatic logic [EW-1:0] model(input logic [3:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    int ua, ub, sa, sb, s, ss;
    logic [W-1:0] r, hi;
    logic c, o, dz, il;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    r = '0; hi = '0; c = 0; o = 0; dz = 0; il = 0;
    case (op)
      4'd0: begin
        s = ua + ub; r = s[W-1:0]; c = (s >= (1 << W));
        ss = sa + sb; o = (ss >= (1 << (W - 1))) || (ss < -(1 << (W - 1)));
      end
      4'd1: begin
        s = ua - ub; r = s[W-1:0]; c = (ua < ub);
        ss = sa - sb; o = (ss >= (1 << (W - 1))) || (ss < -(1 << (W - 1)));
      end
      4'd2: begin
        s = ua * ub; r = s[W-1:0]; hi = s[2*W-1:W]; o = (hi != 0);
      end
      4'd3: begin
        if (ub == 0) begin r = '1; hi = a; dz = 1; end
        else begin r = W'(ua / ub); hi = W'(ua % ub); end
      end
      4'd4: r = a & b;
      4'd5: r = a | b;
      4'd6: r = a ^ b;
      default: begin r = W'('hAC); il = 1; end
    endcase
    return {r, hi, c, (r == 0), o, dz, il};
  endfunction

  task automatic add_vec(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] res, input logic [W-1:0] hi,
                         input logic c, input logic z, input logic o, input logic dz,
                         input logic il, input int lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.res = res; v.hi = hi;
    v.c = c; v.z = z; v.o = o; v.dz = dz; v.il = il; v.lat = lat;
    vecs.push_back(v);
  endtask

  task automatic drive_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.in_valid = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Entered from IDLE just after a rising edge; leaves just after the drain edge.
  task automatic run_vec(input vec_t v, input string name);
    int lat, lows;
    bit got;
    drive_op(v.op, v.a, v.b);
    bus.out_ready = 1'b1;
    @(negedge clock);
    check({name, "_in_ready"}, bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    lat = 0; lows = 0; got = 0;
    for (int n = 1; n <= 20 && !got; n++) begin
      @(negedge clock);
      if (bus.out_valid) begin got = 1; lat = n; end
      else if (!bus.in_ready) lows++;
    end
    check({name, "_latency"}, lat, v.lat);
    check({name, "_busy_cycles"}, lows, v.lat - 1);
    check({name, "_outputs"}, actual(), {v.res, v.hi, v.c, v.z, v.o, v.dz, v.il});
    tick();
  endtask

  task automatic monitor_cycle();
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rand_unexpected: got result %0h with no pending op", bus.result);
      end else begin
        check("rand_result", actual(), exp_q.pop_front());
      end
    end
    if (bus.in_valid && bus.in_ready) exp_q.push_back(model(bus.op, bus.a, bus.b));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] xa[5], xb[5];

    // op, a, b, result, result_hi, carry, zero, overflow, div_zero, illegal, latency
    add_vec(4'd0, 8'hF0, 8'h20, 8'h10, 8'h00, 1, 0, 0, 0, 0, 1);
    add_vec(4'd0, 8'h7F, 8'h01, 8'h80, 8'h00, 0, 0, 1, 0, 0, 1);
    add_vec(4'd1, 8'h80, 8'h01, 8'h7F, 8'h00, 0, 0, 1, 0, 0, 1);
    add_vec(4'd1, 8'h05, 8'h05, 8'h00, 8'h00, 0, 1, 0, 0, 0, 1);
    add_vec(4'd1, 8'h03, 8'h05, 8'hFE, 8'h00, 1, 0, 0, 0, 0, 1);
    add_vec(4'd2, 8'h10, 8'h20, 8'h00, 8'h02, 0, 1, 1, 0, 0, 1);
    add_vec(4'd2, 8'h0F, 8'h0F, 8'hE1, 8'h00, 0, 0, 0, 0, 0, 1);
    add_vec(4'd3, 8'd200, 8'd7, 8'd28, 8'd4, 0, 0, 0, 0, 0, 9);
    add_vec(4'd3, 8'd9, 8'd0, 8'hFF, 8'd9, 0, 0, 0, 1, 0, 1);
    add_vec(4'd3, 8'd3, 8'd7, 8'd0, 8'd3, 0, 1, 0, 0, 0, 9);
    add_vec(4'd3, 8'hFF, 8'h01, 8'hFF, 8'h00, 0, 0, 0, 0, 0, 9);
    add_vec(4'd4, 8'hF0, 8'h3C, 8'h30, 8'h00, 0, 0, 0, 0, 0, 1);
    add_vec(4'd5, 8'hF0, 8'h0F, 8'hFF, 8'h00, 0, 0, 0, 0, 0, 1);
    add_vec(4'd6, 8'hAA, 8'hAA, 8'h00, 8'h00, 0, 1, 0, 0, 0, 1);
    add_vec(4'hB, 8'h12, 8'h34, 8'hAC, 8'h00, 0, 0, 0, 0, 1, 1);

    // Clock/reset
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.op = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_out_valid", bus.out_valid, 0);
    tick();
    reset = 1'b0;
    @(negedge clock);
    check("post_reset_out_valid", bus.out_valid, 0);
    check("post_reset_in_ready", bus.in_ready, 1);
    check("post_reset_outputs", actual(), 0);
    check("post_reset_state", dbg_state, 0);
    tick();

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back XOR, one result per cycle
    bus.out_ready = 1'b1;
    for (int i = 0; i <= 5; i++) begin
      if (i < 5) begin
        xa[i] = W'($urandom);
        xb[i] = W'($urandom);
        drive_op(4'd6, xa[i], xb[i]);
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clock);
      if (i < 5) check("b2b_in_ready", bus.in_ready, 1);
      if (i > 0) begin
        check("b2b_out_valid", bus.out_valid, 1);
        check("b2b_result", bus.result, xa[i-1] ^ xb[i-1]);
      end
      tick();
    end

    // Consumer stall for 3 cycles with a pending offer
    drive_op(4'd0, 8'h33, 8'h44);
    tick();
    drive_op(4'd1, 8'h50, 8'h10);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("stall_out_valid", bus.out_valid, 1);
      check("stall_in_ready", bus.in_ready, 0);
      check("stall_outputs", actual(), model(4'd0, 8'h33, 8'h44));
      tick();
    end
    bus.out_ready = 1'b1;
    @(negedge clock);
    check("stall_release_in_ready", bus.in_ready, 1);
    check("stall_release_outputs", actual(), model(4'd0, 8'h33, 8'h44));
    tick();
    bus.in_valid = 1'b0;
    @(negedge clock);
    check("stall_next_valid", bus.out_valid, 1);
    check("stall_next_outputs", actual(), model(4'd1, 8'h50, 8'h10));
    tick();
    @(negedge clock);
    check("stall_no_duplicate", bus.out_valid, 0);
    tick();

    // Reset on the 4th cycle of a divide
    drive_op(4'd3, 8'd200, 8'd7);
    tick();
    bus.in_valid = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clock);
    check("midreset_out_valid", bus.out_valid, 0);
    check("midreset_in_ready", bus.in_ready, 1);
    check("midreset_outputs", actual(), 0);
    check("midreset_state", dbg_state, 0);
    tick();
    begin
      vec_t v;
      v.op = 4'd0; v.a = 8'h12; v.b = 8'h34; v.res = 8'h46; v.hi = 8'h00;
      v.c = 0; v.z = 0; v.o = 0; v.dz = 0; v.il = 0; v.lat = 1;
      run_vec(v, "after_reset_add");
    end

    // Random traffic with random backpressure
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.op        = 4'($urandom_range(0, 9));
      bus.a         = W'($urandom);
      bus.b         = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clock);
      monitor_cycle();
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clock);
      monitor_cycle();
      tick();
    end
    check("rand_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
